// File: rtl/tc_pkg.sv
// tc_pkg: shared header positions, widths and FSM state type for tc_match_accum
package tc_pkg;
  localparam int TC_HDR_MATCH = 512;
  localparam int TC_HDR_LAST = 513;
  localparam int TC_ACC_W = 64;
  localparam int TC_BEAT_W = 32;
  localparam int TC_POP_W = 10;
  typedef enum logic [1:0] {ACCUM, DRAIN, OUT} tc_state_t;
endpackage

// File: rtl/tc_popcnt512.sv
// tc_popcnt512: two-stage registered popcount of a 512-bit word
// Ports: clk, rst (sync, active-high), in_valid/in_data[511:0] in,
// out_valid/out_cnt[9:0] out two cycles later.
module tc_popcnt512
  import tc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [511:0]        in_data,
  output logic                out_valid,
  output logic [TC_POP_W-1:0] out_cnt
);
  logic [15:0][5:0] s1_d, s1_q;
  logic             v1_q;
  logic [TC_POP_W-1:0] sum_d;
  always_comb begin
    s1_d = '0;
    for (int i = 0; i < 16; i++) s1_d[i] = 6'($countones(in_data[32*i +: 32]));
  end
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < 16; i++) sum_d = sum_d + TC_POP_W'(s1_q[i]);
  end
  always_ff @(posedge clk) begin
    v1_q      <= rst ? 1'b0 : in_valid;
    s1_q      <= rst ? '0 : s1_d;
    out_valid <= rst ? 1'b0 : v1_q;
    out_cnt   <= rst ? '0 : sum_d;
  end
endmodule

// File: rtl/tc_match_accum.sv
// tc_match_accum: popcount CAM match beats, saturating-accumulate, emit one result per graph
// Ports: ap_clk, ap_rst (sync, active-high); p0_* 520-bit input stream
// ([511:0] bitmap, 512 MATCH, 513 LAST); p1_* 128-bit result stream
// ([63:0] total, [127:64] beat count or 0).
// Optional feature macro TC_BEAT_CNT_EN: builds a 32-bit saturating beat counter.
module tc_match_accum
  import tc_pkg::*;
#(
  parameter int C_DATA_WIDTH = 520,
  parameter int C_OUT_WIDTH  = 128
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic [C_DATA_WIDTH-1:0] p0_TDATA,
  input  logic                    p0_TVALID,
  output logic                    p0_TREADY,
  output logic [C_OUT_WIDTH-1:0]  p1_TDATA,
  output logic                    p1_TVALID,
  input  logic                    p1_TREADY
);
  tc_state_t           state_q, state_d;
  logic [1:0]          drain_q, drain_d;
  logic [TC_ACC_W-1:0] acc_q, acc_d;
  logic [TC_ACC_W:0]   sum;
  logic [TC_POP_W-1:0] pop_cnt;
  logic                pop_v, fire, last, clear;
  logic                unused_hdr;
  assign unused_hdr = ^p0_TDATA[C_DATA_WIDTH-1:TC_HDR_LAST+1];
  assign p0_TREADY  = (state_q == ACCUM) && !ap_rst;
  assign p1_TVALID  = (state_q == OUT);
  assign fire       = p0_TVALID && p0_TREADY;
  assign last       = fire && p0_TDATA[TC_HDR_LAST];
  assign clear      = p1_TVALID && p1_TREADY;
  // MATCH=0 beats still occupy a pipeline slot but contribute zero
  tc_popcnt512 u_pop (
    .clk      (ap_clk),
    .rst      (ap_rst),
    .in_valid (fire),
    .in_data  (p0_TDATA[TC_HDR_MATCH] ? p0_TDATA[511:0] : 512'd0),
    .out_valid(pop_v),
    .out_cnt  (pop_cnt)
  );
  // the carry out of the 65-bit sum pins the total at all ones
  assign sum = {1'b0, acc_q} + (TC_ACC_W+1)'(pop_cnt);
  always_comb acc_d = clear ? '0 : !pop_v ? acc_q : sum[TC_ACC_W] ? '1 : sum[TC_ACC_W-1:0];
  // two drain cycles plus the exit cycle cover the two popcount stages and the accumulate
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ACCUM: begin
        state_d = last ? DRAIN : ACCUM;
        drain_d = last ? 2'd2 : drain_q;
      end
      DRAIN: begin
        state_d = (drain_q == 2'd0) ? OUT : DRAIN;
        drain_d = (drain_q == 2'd0) ? drain_q : drain_q - 2'd1;
      end
      OUT:     state_d = p1_TREADY ? ACCUM : OUT;
      default: state_d = ACCUM;
    endcase
  end
  always_ff @(posedge ap_clk) begin
    state_q <= ap_rst ? ACCUM : state_d;
    drain_q <= ap_rst ? 2'd0 : drain_d;
    acc_q   <= ap_rst ? '0 : acc_d;
  end
`ifdef TC_BEAT_CNT_EN
  logic [TC_BEAT_W-1:0] beats_q, beats_d;
  always_comb beats_d = clear ? '0 : (fire && !(&beats_q)) ? beats_q + 1'b1 : beats_q;
  always_ff @(posedge ap_clk) beats_q <= ap_rst ? '0 : beats_d;
  assign p1_TDATA = {(C_OUT_WIDTH-TC_ACC_W)'(beats_q), acc_q};
`else
  assign p1_TDATA = {{(C_OUT_WIDTH-TC_ACC_W){1'b0}}, acc_q};
`endif
endmodule

// File: tb/tb_tc_match_accum.sv
// tb_tc_match_accum: directed self-checking bench for tc_match_accum
module tb_tc_match_accum;
`ifdef TC_BEAT_CNT_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [519:0] p0_tdata = '0;
  logic         p0_tvalid = 1'b0;
  logic         p0_tready;
  logic [127:0] p1_tdata;
  logic         p1_tvalid;
  logic         p1_tready = 1'b0;
  int           vectors = 0;
  int           errors = 0;
  always #5 clk = ~clk;
  tc_match_accum dut (
    .ap_clk   (clk),
    .ap_rst   (rst),
    .p0_TDATA (p0_tdata),
    .p0_TVALID(p0_tvalid),
    .p0_TREADY(p0_tready),
    .p1_TDATA (p1_tdata),
    .p1_TVALID(p1_tvalid),
    .p1_TREADY(p1_tready)
  );
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic match, input logic last, input logic [511:0] bm);
    p0_tdata  = {6'($urandom), last, match, bm};
    p0_tvalid = 1'b1;
    tick();
    p0_tvalid = 1'b0;
  endtask
  task automatic wait_out(input string tag);
    for (int k = 0; k < 8 && !p1_tvalid; k++) tick();
    check(tag, {127'd0, p1_tvalid}, 128'd1);
  endtask
  task automatic handshake();
    p1_tready = 1'b1;
    tick();
    p1_tready = 1'b0;
  endtask
  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction
  function automatic logic [127:0] res(input logic [63:0] hi, input logic [63:0] tot);
    return {BC ? hi : 64'd0, tot};
  endfunction
  logic [511:0] bm;
  logic [63:0]  model;
  logic         m;
  initial begin
    tick();
    tick();
    check("rst_tready", {127'd0, p0_tready}, 128'd0);
    check("rst_tvalid", {127'd0, p1_tvalid}, 128'd0);
    check("rst_tdata", p1_tdata, 128'd0);
    rst = 1'b0;
    #1;
    check("post_rst_tready", {127'd0, p0_tready}, 128'd1);
    // three match beats then a LAST-only beat: 512 + 1 + 256
    send(1'b1, 1'b0, {512{1'b1}});
    send(1'b1, 1'b0, 512'd1);
    send(1'b1, 1'b0, {128{4'hA}});
    send(1'b0, 1'b1, {512{1'b1}});
    check("lat_e0_tready", {127'd0, p0_tready}, 128'd0);
    check("lat_e0_tvalid", {127'd0, p1_tvalid}, 128'd0);
    tick();
    check("lat_e1_tvalid", {127'd0, p1_tvalid}, 128'd0);
    tick();
    check("lat_e2_tvalid", {127'd0, p1_tvalid}, 128'd0);
    tick();
    check("lat_e3_tvalid", {127'd0, p1_tvalid}, 128'd1);
    check("sum769", p1_tdata, res(64'd4, 64'd769));
    handshake();
    check("hs_tvalid", {127'd0, p1_tvalid}, 128'd0);
    check("hs_tready", {127'd0, p0_tready}, 128'd1);
    // empty graph
    send(1'b0, 1'b1, rnd512());
    wait_out("empty_wait");
    check("empty", p1_tdata, res(64'd1, 64'd0));
    handshake();
    // output backpressure for 10 cycles
    send(1'b1, 1'b1, 512'hF);
    wait_out("stall_wait");
    for (int k = 0; k < 10; k++) begin
      check("stall_tvalid", {127'd0, p1_tvalid}, 128'd1);
      check("stall_tready", {127'd0, p0_tready}, 128'd0);
      check("stall_data", p1_tdata, res(64'd1, 64'd4));
      tick();
    end
    handshake();
    send(1'b1, 1'b1, 512'h7 << 300);
    wait_out("fresh_wait");
    check("fresh", p1_tdata, res(64'd1, 64'd3));
    handshake();
    // 1000 random beats with random valid gaps
    model = '0;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 2) == 0) tick();
      bm = rnd512();
      m  = ($urandom_range(0, 3) != 0);
      if (m) model = model + 64'($countones(bm));
      send(m, i == 999, bm);
    end
    wait_out("rand_wait");
    check("rand_sum", p1_tdata, res(64'd1000, model));
    handshake();
    // saturation from a preloaded total
    dut.acc_q = 64'hFFFF_FFFF_FFFF_FFFB;
    tick();
    send(1'b1, 1'b1, {512{1'b1}});
    wait_out("sat_wait");
    check("saturate", p1_tdata, res(64'd1, 64'hFFFF_FFFF_FFFF_FFFF));
    handshake();
    // reset while draining drops the pending result
    send(1'b1, 1'b1, 512'hFF);
    rst = 1'b1;
    #1;
    check("rst_mid_tready", {127'd0, p0_tready}, 128'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("rst_drop_tvalid", {127'd0, p1_tvalid}, 128'd0);
      tick();
    end
    check("rst_drop_tdata", p1_tdata, 128'd0);
    check("rst_drop_tready", {127'd0, p0_tready}, 128'd1);
    send(1'b1, 1'b1, 512'h7F << 100);
    wait_out("after_rst_wait");
    check("after_rst", p1_tdata, res(64'd1, 64'd7));
    handshake();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
